// File: rtl/pinfilter_sched_pkg.sv
// Shared types and helpers for the pin-filter sequencer.
// State encoding and width helpers used across the slice.
package gpio_sched_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int N_DEF    = 8;
    localparam int DIVW_DEF = 16;
    localparam int CW       = $clog2(N_DEF);

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pinfilter_sched_if.sv
// Event handshake between the sequencer and its consumer.
// master drives the event, slave returns ready.
interface pinfilter_sched_if #(
    parameter int N = 8
);
    import gpio_sched_pkg::*;

    localparam int CW = cw_of(N);

    logic          evt_valid;
    logic          evt_ready;
    logic [CW-1:0] evt_chan;
    logic          evt_level;
    logic          evt_overrun;

    modport master (
        output evt_valid, evt_chan, evt_level, evt_overrun,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_chan, evt_level, evt_overrun,
        output evt_ready
    );

endinterface

// File: rtl/pinfilter_sched_rr_pick.sv
// Round-robin pick: first set request strictly after ptr, with wrap.
// Rotate so ptr+1 sits at bit 0, priority-encode, then add the offset back.
module rr_pick
    import gpio_sched_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = cw_of(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] gnt_idx,
    output logic          any
);

    logic [CW-1:0] start;
    logic [N-1:0]  rot;
    logic [CW-1:0] pe;
    logic [CW:0]   sum;

    always_comb begin
        start = (ptr == CW'(N - 1)) ? '0 : ptr + CW'(1);
        rot   = N'({req, req} >> start);
        pe    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pe = CW'(i);
        end
        sum = {1'b0, pe} + {1'b0, start};
        if (sum >= (CW+1)'(N)) begin
            gnt_idx = CW'(sum - (CW+1)'(N));
        end else begin
            gnt_idx = CW'(sum);
        end
        any = |req;
    end

endmodule

// File: rtl/pinfilter_sched.sv
// Sample-strobe prescaler plus edge latch and round-robin event reporter
// for a bank of filtered GPIO channels.
module pinfilter_sched
    import gpio_sched_pkg::*;
#(
    parameter int N    = 8,
    parameter int DIVW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            cfg_en,
    input  logic [DIVW-1:0] cfg_div,
    output logic            sample_ena,
    input  logic [N-1:0]    filt_in,
    output logic [N-1:0]    pending,
    pinfilter_sched_if.master evt
);

    localparam int CW = cw_of(N);

    logic [DIVW-1:0] cnt;
    logic [N-1:0]    prev;
    logic [N-1:0]    lvl;
    logic [N-1:0]    ovr;
    logic [N-1:0]    edg;
    logic            dirty;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   gnt;
    logic [CW-1:0]   own;
    logic            any;
    logic            own_act;
    logic            hs;
    state_t          state;
    state_t          state_nx;

    assign edg = filt_in ^ prev;

    rr_pick #(.N(N), .CW(CW)) u_pick (
        .req    (pending),
        .ptr    (ptr),
        .gnt_idx(gnt),
        .any    (any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            sample_ena <= 1'b0;
        end else if (!cfg_en) begin
            cnt        <= cfg_div;
            sample_ena <= 1'b0;
        end else if (cnt == '0) begin
            cnt        <= cfg_div;
            sample_ena <= 1'b1;
        end else begin
            cnt        <= cnt - 1'b1;
            sample_ena <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any)           state_nx = PRESENT;
            PRESENT: if (evt.evt_ready) state_nx = IDLE;
        endcase
    end

    // own is the channel being snapshotted (IDLE) or presented (PRESENT)
    always_comb begin
        evt.evt_valid = 1'b0;
        own_act       = 1'b0;
        own           = evt.evt_chan;
        hs            = 1'b0;
        unique case (state)
            IDLE: begin
                own_act = any;
                own     = gnt;
            end
            PRESENT: begin
                evt.evt_valid = 1'b1;
                own_act       = 1'b1;
                hs            = evt.evt_ready;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev            <= '1;
            lvl             <= '1;
            pending         <= '0;
            ovr             <= '0;
            dirty           <= 1'b0;
            ptr             <= CW'(N - 1);
            evt.evt_chan    <= '0;
            evt.evt_level   <= 1'b1;
            evt.evt_overrun <= 1'b0;
        end else begin
            prev <= filt_in;
            for (int i = 0; i < N; i++) begin
                if (edg[i]) lvl[i] <= filt_in[i];
                if (own_act && (CW'(i) == own)) begin
                    if (state == IDLE) begin
                        ovr[i] <= 1'b0;
                    end else begin
                        if (edg[i] && dirty) ovr[i] <= 1'b1;
                        if (hs) pending[i] <= dirty | edg[i];
                    end
                end else if (edg[i]) begin
                    if (pending[i]) ovr[i]     <= 1'b1;
                    else            pending[i] <= 1'b1;
                end
            end
            if (state == IDLE && any) begin
                evt.evt_chan    <= gnt;
                evt.evt_level   <= edg[gnt] ? filt_in[gnt] : lvl[gnt];
                evt.evt_overrun <= ovr[gnt];
                dirty           <= edg[gnt];
            end else if (state == PRESENT) begin
                if (edg[own]) dirty <= 1'b1;
                if (hs)       ptr   <= own;
            end
        end
    end

endmodule

// File: tb/tb_pinfilter_sched.sv
// Directed and randomized bench for pinfilter_sched against a
// channel-level reference model.
module tb_pinfilter_sched;

    localparam int N = 8;

    logic        clk;
    logic        reset_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic        sample_ena;
    logic [N-1:0] filt_in;
    logic [N-1:0] pending;

    pinfilter_sched_if #(.N(N)) evt();

    pinfilter_sched #(.N(N), .DIVW(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .sample_ena(sample_ena),
        .filt_in   (filt_in),
        .pending   (pending),
        .evt       (evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int chan;
        bit lvl;
        bit ovf;
        int t;
    } ev_t;

    ev_t evq[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  cyc_n  = 0;

    bit m_prev[N], m_lvl[N], m_pend[N], m_ovr[N];
    bit m_busy, m_dirty, m_se, m_level, m_ovf;
    int m_ptr, m_chan, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t ev_at(input int k);
        ev_t none;
        none = '{-1, 1'b0, 1'b0, -1};
        if (k < evq.size()) return evq[k];
        return none;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 1'b1;
            m_lvl[i]  = 1'b1;
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
        end
        m_busy = 0; m_dirty = 0; m_se = 0; m_level = 1; m_ovf = 0;
        m_ptr = N - 1; m_chan = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en, input int div,
                              input logic [N-1:0] fin, input bit rdy);
        bit e[N];
        int c;
        int owner;
        bit d_old;
        for (int i = 0; i < N; i++) e[i] = (fin[i] != m_prev[i]);
        if (!en) begin
            m_se = 0; m_cnt = div;
        end else if (m_cnt == 0) begin
            m_se = 1; m_cnt = div;
        end else begin
            m_se = 0; m_cnt--;
        end
        c = -1;
        owner = -1;
        d_old = m_dirty;
        if (m_busy) owner = m_chan;
        else begin
            for (int k = 1; k <= N; k++) begin
                if (c < 0 && m_pend[(m_ptr + k) % N]) c = (m_ptr + k) % N;
            end
        end
        if (c >= 0) begin
            owner   = c;
            m_chan  = c;
            m_level = e[c] ? fin[c] : m_lvl[c];
            m_ovf   = m_ovr[c];
            m_ovr[c] = 0;
            m_dirty = e[c];
            m_busy  = 1;
        end else if (m_busy) begin
            if (e[owner]) begin
                if (d_old) m_ovr[owner] = 1;
                m_dirty = 1;
            end
            if (rdy) begin
                m_pend[owner] = d_old | e[owner];
                m_ptr  = owner;
                m_busy = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (i != owner && e[i]) begin
                if (m_pend[i]) m_ovr[i] = 1;
                else           m_pend[i] = 1;
            end
            if (e[i]) m_lvl[i] = fin[i];
            m_prev[i] = fin[i];
        end
    endtask

    task automatic compare_all();
        logic [N-1:0] pv;
        for (int i = 0; i < N; i++) pv[i] = m_pend[i];
        chk("sample_ena", sample_ena, m_se);
        chk("evt_valid", evt.evt_valid, m_busy);
        chk("evt_chan", evt.evt_chan, m_chan);
        chk("evt_level", evt.evt_level, m_level);
        chk("evt_overrun", evt.evt_overrun, m_ovf);
        chk("pending", pending, pv);
    endtask

    // called at a falling edge; applies inputs across one rising edge
    task automatic step(input bit en, input int div,
                        input logic [N-1:0] fin, input bit rdy);
        cfg_en        = en;
        cfg_div       = 16'(div);
        filt_in       = fin;
        evt.evt_ready = rdy;
        if (evt.evt_valid && rdy)
            evq.push_back('{int'(evt.evt_chan), evt.evt_level,
                            evt.evt_overrun, cyc_n});
        @(posedge clk);
        model_step(en, div, fin, rdy);
        cyc_n++;
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int s;
        logic [N-1:0] cur;
        reset_n = 1'b0;
        cfg_en = 1'b0;
        cfg_div = '0;
        filt_in = '1;
        evt.evt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_sample_ena", sample_ena, 0);
        chk("rst_valid", evt.evt_valid, 0);
        chk("rst_chan", evt.evt_chan, 0);
        chk("rst_level", evt.evt_level, 1);
        chk("rst_overrun", evt.evt_overrun, 0);
        chk("rst_pending", pending, 0);
        reset_n = 1'b1;

        s = 0;
        repeat (12) begin
            step(1, 3, 8'hFF, 0);
            s += int'(sample_ena);
        end
        chk("t1_div3_strobes", s, 3);
        s = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 8'hFF, 0);
            if (k >= 4) s += int'(sample_ena);
        end
        chk("t1_div0_strobes", s, 4);
        step(0, 0, 8'hFF, 0);
        chk("t1_disable", sample_ena, 0);

        evq.delete();
        repeat (4) step(0, 0, 8'hFE, 1);
        chk("t2_count", evq.size(), 1);
        chk("t2_chan", ev_at(0).chan, 0);
        chk("t2_level", ev_at(0).lvl, 0);
        chk("t2_ovf", ev_at(0).ovf, 0);
        chk("t2_pending", pending, 0);

        evq.delete();
        step(0, 0, 8'hDE, 0);
        step(0, 0, 8'hDE, 0);
        step(0, 0, 8'hBC, 0);
        repeat (9) step(0, 0, 8'hBC, 1);
        chk("t3_count", evq.size(), 4);
        chk("t3_first", ev_at(1).chan, 6);
        chk("t3_second", ev_at(2).chan, 1);
        chk("t3_third", ev_at(3).chan, 5);
        chk("t3_lvl6", ev_at(1).lvl, 0);
        chk("t3_lvl1", ev_at(2).lvl, 0);
        chk("t3_lvl5", ev_at(3).lvl, 1);
        chk("t3_gap_a", ev_at(2).t - ev_at(1).t, 2);
        chk("t3_gap_b", ev_at(3).t - ev_at(2).t, 2);

        evq.delete();
        step(0, 0, 8'hBD, 0);
        step(0, 0, 8'hBD, 0);
        step(0, 0, 8'hB5, 0);
        step(0, 0, 8'hBD, 0);
        repeat (4) step(0, 0, 8'hBD, 1);
        chk("t4_count", evq.size(), 2);
        chk("t4_chan", ev_at(1).chan, 3);
        chk("t4_level", ev_at(1).lvl, 1);
        chk("t4_ovf", ev_at(1).ovf, 1);
        chk("t4_prior_ovf", ev_at(0).ovf, 0);

        evq.delete();
        step(0, 0, 8'hB9, 0);
        step(0, 0, 8'hB9, 0);
        step(0, 0, 8'hBD, 0);
        step(0, 0, 8'hBD, 1);
        chk("t5_pending2", pending[2], 1);
        repeat (3) step(0, 0, 8'hBD, 1);
        chk("t5_count", evq.size(), 2);
        chk("t5_chan", ev_at(1).chan, 2);
        chk("t5_level", ev_at(1).lvl, 1);
        chk("t5_ovf", ev_at(1).ovf, 0);

        step(0, 0, 8'hAD, 0);
        step(0, 0, 8'hAD, 0);
        chk("t6_valid_before", evt.evt_valid, 1);
        #2;
        reset_n = 1'b0;
        filt_in = 8'hFF;
        #1;
        chk("t6_valid_async", evt.evt_valid, 0);
        chk("t6_pending_async", pending, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        evq.delete();
        repeat (5) step(0, 0, 8'hFF, 1);
        chk("t6_no_event", evq.size(), 0);

        cur = 8'hFF;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 2) == 0)
                cur = cur ^ N'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 7) == 0)
                cur = cur ^ N'(1 << $urandom_range(0, N - 1));
            step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 cur, bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
